// File: rtl/pcie_compliance_req_ctrl_if.sv
// pcie_compliance_req_ctrl_if: request inputs, LTSSM status and hard-IP test controls
// Revision: 1.0
`default_nettype none

interface pcie_compliance_req_ctrl_if;
  logic       req_compliance_push_button_n;
  logic       req_compliance_soft_ctrl;
  logic       set_compliance_mode;
  logic [4:0] ltssm_state;
  logic       test_in_32_hip;
  logic       test_in_5_hip;
  logic       compl_active;
  logic       compl_timeout;
  logic [7:0] compl_entry_cnt;

  modport master (
    output req_compliance_push_button_n, req_compliance_soft_ctrl,
           set_compliance_mode, ltssm_state,
    input  test_in_32_hip, test_in_5_hip, compl_active, compl_timeout,
           compl_entry_cnt
  );

  modport slave (
    input  req_compliance_push_button_n, req_compliance_soft_ctrl,
           set_compliance_mode, ltssm_state,
    output test_in_32_hip, test_in_5_hip, compl_active, compl_timeout,
           compl_entry_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pcie_compliance_req_ctrl.sv
// pcie_compliance_req_ctrl: debounced compliance request, timed force pulses, LTSSM-confirmed entry/exit
// Revision: 1.0
`default_nettype none

module pcie_compliance_req_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 65536,
  parameter int         PULSE_CYCLES    = 16,
  parameter int         TIMEOUT_CYCLES  = 1048576,
  parameter logic [4:0] LTSSM_COMPL     = 5'b00011
) (
  input  wire logic                   pld_clk,
  input  wire logic                   pld_rst,
  pcie_compliance_req_ctrl_if.slave   bus
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TMR_MAX = (TIMEOUT_CYCLES > PULSE_CYCLES) ? TIMEOUT_CYCLES : PULSE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  localparam logic [DB_W-1:0]  c_DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_TMR_MAX    = TMR_W'(TMR_MAX);
  localparam logic [TMR_W-1:0] c_PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_TO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ENTER_PULSE = 3'd1,
    WAIT_ENTRY  = 3'd2,
    IN_COMPL    = 3'd3,
    EXIT_PULSE  = 3'd4,
    WAIT_EXIT   = 3'd5
  } state_t;

  logic            r_btn_s1, r_btn_s2, r_soft_s1, r_soft_s2, r_soft_d;
  logic            r_mode_s1, r_mode_s2;
  logic            r_db_level;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press;
  logic            w_btn_fall, w_soft_rise, w_ltssm_compl;

  state_t          r_state, w_next;
  logic [TMR_W-1:0] r_tmr;
  logic            r_test32, r_test5, r_active, r_timeout;
  logic [7:0]      r_entry_cnt;
  logic            w_to_set, w_to_clr, w_entry;

  // Debounced level flips on the last of DEBOUNCE_CYCLES consecutive mismatching cycles
  assign w_btn_fall    = (r_btn_s2 != r_db_level) && (r_db_cnt == c_DB_LAST) && !r_btn_s2;
  assign w_soft_rise   = r_soft_s2 && !r_soft_d;
  assign w_ltssm_compl = (bus.ltssm_state == LTSSM_COMPL);

  always_ff @(posedge pld_clk) begin
    if (pld_rst) begin
      r_btn_s1   <= 1'b1;
      r_btn_s2   <= 1'b1;
      r_soft_s1  <= 1'b0;
      r_soft_s2  <= 1'b0;
      r_soft_d   <= 1'b0;
      r_mode_s1  <= 1'b0;
      r_mode_s2  <= 1'b0;
      r_db_level <= 1'b1;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_btn_s1  <= bus.req_compliance_push_button_n;
      r_btn_s2  <= r_btn_s1;
      r_soft_s1 <= bus.req_compliance_soft_ctrl;
      r_soft_s2 <= r_soft_s1;
      r_soft_d  <= r_soft_s2;
      r_mode_s1 <= bus.set_compliance_mode;
      r_mode_s2 <= r_mode_s1;
      if (r_btn_s2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
        r_db_level <= r_btn_s2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      r_press <= w_btn_fall || w_soft_rise;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_to_set = 1'b0;
    w_to_clr = 1'b0;
    w_entry  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_press && r_mode_s2) w_next = ENTER_PULSE;
      end
      ENTER_PULSE: begin
        if (r_tmr == c_PULSE_LAST) w_next = WAIT_ENTRY;
      end
      WAIT_ENTRY: begin
        if (w_ltssm_compl) begin
          w_next   = IN_COMPL;
          w_entry  = 1'b1;
          w_to_clr = 1'b1;
        end else if (r_tmr == c_TO_LAST) begin
          w_next   = IDLE;
          w_to_set = 1'b1;
        end
      end
      IN_COMPL: begin
        // Exit is honoured even with compliance mode switched off
        if (r_press)             w_next = EXIT_PULSE;
        else if (!w_ltssm_compl) w_next = IDLE;
      end
      EXIT_PULSE: begin
        if (r_tmr == c_PULSE_LAST) w_next = WAIT_EXIT;
      end
      WAIT_EXIT: begin
        if (!w_ltssm_compl) begin
          w_next   = IDLE;
          w_to_clr = 1'b1;
        end else if (r_tmr == c_TO_LAST) begin
          w_next   = IN_COMPL;
          w_to_set = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pld_clk) begin
    if (pld_rst) begin
      r_state     <= IDLE;
      r_tmr       <= '0;
      r_test32    <= 1'b0;
      r_test5     <= 1'b1;
      r_active    <= 1'b0;
      r_timeout   <= 1'b0;
      r_entry_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)   r_tmr <= '0;
      else if (r_tmr != c_TMR_MAX) r_tmr <= r_tmr + 1'b1;
      r_test32 <= (w_next == ENTER_PULSE) || (w_next == EXIT_PULSE);
      r_test5  <= !r_mode_s2;
      r_active <= (w_next == IN_COMPL) || (w_next == EXIT_PULSE) || (w_next == WAIT_EXIT);
      if (w_to_set)      r_timeout <= 1'b1;
      else if (w_to_clr) r_timeout <= 1'b0;
      if (w_entry && (r_entry_cnt != 8'hFF)) r_entry_cnt <= r_entry_cnt + 8'd1;
    end
  end

  assign bus.test_in_32_hip  = r_test32;
  assign bus.test_in_5_hip   = r_test5;
  assign bus.compl_active    = r_active;
  assign bus.compl_timeout   = r_timeout;
  assign bus.compl_entry_cnt = r_entry_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pcie_compliance_req_ctrl.sv
// tb_pcie_compliance_req_ctrl: directed checks of debounce, entry/exit, timeout, gating and reset
// Revision: 1.0
`default_nettype none

module tb_pcie_compliance_req_ctrl;
  logic pld_clk = 1'b0;
  logic pld_rst = 1'b1;

  pcie_compliance_req_ctrl_if bus ();

  pcie_compliance_req_ctrl #(
    .DEBOUNCE_CYCLES (8),
    .PULSE_CYCLES    (4),
    .TIMEOUT_CYCLES  (64),
    .LTSSM_COMPL     (5'b00011)
  ) dut (
    .pld_clk (pld_clk),
    .pld_rst (pld_rst),
    .bus     (bus)
  );

  always #5 pld_clk = ~pld_clk;

  int n_checks = 0;
  int n_errors = 0;
  int q_exp[$];
  int q_obs[$];
  int pulse_w = 0;

  // Pulse monitor: widths of completed test_in_32_hip pulses
  always @(negedge pld_clk) begin
    if (bus.test_in_32_hip === 1'b1) begin
      pulse_w = pulse_w + 1;
    end else if (pulse_w != 0) begin
      q_obs.push_back(pulse_w);
      pulse_w = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pld_clk);
  endtask

  task automatic wait_t32(input logic lvl, input int max, input string tag);
    int n;
    n = 0;
    while (bus.test_in_32_hip !== lvl && n < max) begin
      @(negedge pld_clk);
      n++;
    end
    chk(tag, bus.test_in_32_hip, lvl);
  endtask

  task automatic check_pulses(input string tag);
    int e;
    int o;
    while (q_exp.size() > 0 || q_obs.size() > 0) begin
      e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
      o = (q_obs.size() > 0) ? q_obs.pop_front() : -1;
      chk(tag, o, e);
    end
  endtask

  initial begin
    bus.req_compliance_push_button_n = 1'b1;
    bus.req_compliance_soft_ctrl     = 1'b0;
    bus.set_compliance_mode          = 1'b0;
    bus.ltssm_state                  = 5'b00000;
    tick(3);
    pld_rst = 1'b0;
    chk("rst_t32", bus.test_in_32_hip, 1'b0);
    chk("rst_t5", bus.test_in_5_hip, 1'b1);
    chk("rst_active", bus.compl_active, 1'b0);
    chk("rst_timeout", bus.compl_timeout, 1'b0);
    chk("rst_cnt", bus.compl_entry_cnt, 8'd0);

    // Soft request while compliance mode is off is ignored
    bus.req_compliance_soft_ctrl = 1'b1;
    tick(12);
    chk("gate_t5", bus.test_in_5_hip, 1'b1);
    chk("gate_nopulse", q_obs.size(), 0);
    bus.req_compliance_soft_ctrl = 1'b0;
    tick(4);

    bus.set_compliance_mode = 1'b1;
    tick(2);
    chk("mode_t5_c2", bus.test_in_5_hip, 1'b1);
    tick(1);
    chk("mode_t5_c3", bus.test_in_5_hip, 1'b0);

    // Bouncing button: one pulse only; attempt then times out
    q_exp.push_back(4);
    bus.req_compliance_push_button_n = 1'b0; tick(5);
    bus.req_compliance_push_button_n = 1'b1; tick(2);
    bus.req_compliance_push_button_n = 1'b0; tick(10);
    bus.req_compliance_push_button_n = 1'b1;
    tick(100);
    check_pulses("bounce_pulse");
    chk("bounce_timeout", bus.compl_timeout, 1'b1);

    // Entry via soft request
    q_exp.push_back(4);
    bus.req_compliance_soft_ctrl = 1'b1;
    tick(3);
    chk("soft_lat_c3", bus.test_in_32_hip, 1'b0);
    tick(1);
    chk("soft_lat_c4", bus.test_in_32_hip, 1'b1);
    wait_t32(1'b0, 10, "entry_pulse_end");
    chk("entry_pre_active", bus.compl_active, 1'b0);
    bus.ltssm_state = 5'b00011;
    tick(1);
    chk("entry_active", bus.compl_active, 1'b1);
    chk("entry_cnt", bus.compl_entry_cnt, 8'd1);
    chk("entry_timeout_clr", bus.compl_timeout, 1'b0);
    tick(19);
    chk("entry_hold", bus.compl_active, 1'b1);
    bus.req_compliance_soft_ctrl = 1'b0;

    // Exit via button
    q_exp.push_back(4);
    bus.req_compliance_push_button_n = 1'b0;
    wait_t32(1'b1, 20, "exit_pulse_start");
    chk("exit_active_pulse", bus.compl_active, 1'b1);
    wait_t32(1'b0, 10, "exit_pulse_end");
    bus.req_compliance_push_button_n = 1'b1;
    bus.ltssm_state = 5'b00000;
    tick(1);
    chk("exit_active", bus.compl_active, 1'b0);
    tick(20);
    check_pulses("exit_pulses");

    // Entry timeout
    bus.ltssm_state = 5'b01111;
    q_exp.push_back(4);
    bus.req_compliance_soft_ctrl = 1'b1;
    wait_t32(1'b1, 10, "to_pulse_start");
    wait_t32(1'b0, 10, "to_pulse_end");
    chk("to_pre", bus.compl_timeout, 1'b0);
    tick(63);
    chk("to_c63", bus.compl_timeout, 1'b0);
    tick(1);
    chk("to_c64", bus.compl_timeout, 1'b1);
    chk("to_cnt", bus.compl_entry_cnt, 8'd1);
    bus.req_compliance_soft_ctrl = 1'b0;
    tick(4);
    check_pulses("to_pulses");

    // Button and soft edge coinciding, then a discarded press in WAIT_ENTRY
    q_exp.push_back(4);
    bus.req_compliance_push_button_n = 1'b0;
    tick(7);
    bus.req_compliance_soft_ctrl = 1'b1;
    wait_t32(1'b1, 10, "ovl_pulse_start");
    wait_t32(1'b0, 10, "ovl_pulse_end");
    bus.req_compliance_push_button_n = 1'b1;
    bus.req_compliance_soft_ctrl = 1'b0;
    tick(3);
    bus.req_compliance_soft_ctrl = 1'b1;
    tick(80);
    chk("ovl_timeout", bus.compl_timeout, 1'b1);
    check_pulses("ovl_pulses");

    // Saturating entry counter
    for (int i = 0; i < 256; i++) begin
      bus.req_compliance_soft_ctrl = 1'b0;
      tick(2);
      bus.req_compliance_soft_ctrl = 1'b1;
      q_exp.push_back(4);
      wait_t32(1'b1, 10, "sat_pulse_start");
      wait_t32(1'b0, 10, "sat_pulse_end");
      bus.ltssm_state = 5'b00011;
      tick(2);
      bus.ltssm_state = 5'b00000;
      tick(2);
      if (i == 253) chk("sat_reach_255", bus.compl_entry_cnt, 8'd255);
    end
    chk("sat_hold_255", bus.compl_entry_cnt, 8'd255);
    chk("sat_spont_exit", bus.compl_active, 1'b0);
    check_pulses("sat_pulses");

    // Reset in pulse cycle 2
    bus.req_compliance_soft_ctrl = 1'b0;
    tick(3);
    bus.req_compliance_soft_ctrl = 1'b1;
    q_exp.push_back(2);
    wait_t32(1'b1, 10, "rstp_pulse_start");
    tick(1);
    pld_rst = 1'b1;
    bus.req_compliance_soft_ctrl = 1'b0;
    tick(1);
    chk("rstp_t32", bus.test_in_32_hip, 1'b0);
    chk("rstp_t5", bus.test_in_5_hip, 1'b1);
    chk("rstp_active", bus.compl_active, 1'b0);
    chk("rstp_timeout", bus.compl_timeout, 1'b0);
    chk("rstp_cnt", bus.compl_entry_cnt, 8'd0);
    pld_rst = 1'b0;
    tick(10);
    check_pulses("final_pulses");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
